// File: rtl/io_map_multi.sv
`default_nettype none
// ============================================================================
// Module      : io_map_multi
// Description : Memory-mapped I/O for N players (debounced trigger/sensor,
//               sticky events, saturating hit count), M one-shot sound timers
//               and a 10-bit LFSR random source.
// Revision    : 1.0 - initial release
// ============================================================================
module io_map_multi #(
    parameter int                NUM_PLAYERS = 2,
    parameter int                NUM_SOUNDS  = 8,
    parameter int                DATA_W      = 18,
    parameter int                ADDR_W      = 16,
    parameter logic [ADDR_W-1:0] IO_BASE     = 16'h2000,
    parameter int                DEB_CYC     = 4,
    parameter int                PULSE_LEN   = 8
) (
    input  logic                   CLK,
    input  logic                   CLR,
    input  logic [NUM_PLAYERS-1:0] trigger,
    input  logic [NUM_PLAYERS-1:0] sens,
    output logic [NUM_PLAYERS-1:0] shot,
    output logic [NUM_PLAYERS-1:0] hit,
    output logic [NUM_SOUNDS-1:0]  sound,
    input  logic                   bus_wr,
    input  logic [ADDR_W-1:0]      bus_addr,
    input  logic [DATA_W-1:0]      bus_din,
    output logic [DATA_W-1:0]      bus_dout,
    output logic                   bus_sel,
    output logic [9:0]             rand_out
);

    localparam int c_NIN     = 2 * NUM_PLAYERS;
    localparam int c_DEB_W   = $clog2(DEB_CYC + 1);
    localparam int c_PULSE_W = $clog2(PULSE_LEN + 1);
    localparam logic [c_DEB_W-1:0]   c_DEB_LAST  = c_DEB_W'(DEB_CYC - 1);
    localparam logic [c_PULSE_W-1:0] c_PULSE_LD  = c_PULSE_W'(PULSE_LEN);
    localparam logic [c_PULSE_W-1:0] c_PULSE_ONE = c_PULSE_W'(1);
    localparam logic [DATA_W-1:0]    c_TMR_ONE   = DATA_W'(1);

    generate
        if (c_NIN > DATA_W) begin : g_chk_lvl_width
            $error("io_map_multi: 2*NUM_PLAYERS must not exceed DATA_W");
        end
        if (IO_BASE[7:0] != 8'h00) begin : g_chk_base_align
            $error("io_map_multi: IO_BASE low 8 bits must be zero");
        end
        if (NUM_PLAYERS < 1 || NUM_PLAYERS > 16 || NUM_SOUNDS < 1 || NUM_SOUNDS > 16) begin : g_chk_counts
            $error("io_map_multi: NUM_PLAYERS and NUM_SOUNDS must be 1..16");
        end
        if (DATA_W < 10 || DEB_CYC < 1 || PULSE_LEN < 1 || ADDR_W <= 8) begin : g_chk_misc
            $error("io_map_multi: illegal DATA_W/DEB_CYC/PULSE_LEN/ADDR_W");
        end
    endgenerate

    // Address decode shared by write strobes and read mux
    logic [ADDR_W-1:0] w_off;
    logic              w_dec;
    logic [7:0]        w_lo;

    assign w_off = bus_addr - IO_BASE;
    assign w_dec = (w_off[ADDR_W-1:8] == '0);
    assign w_lo  = w_off[7:0];

    // Inputs interleaved so the vector matches the level register layout
    logic [c_NIN-1:0] w_raw;
    logic [c_NIN-1:0] w_lvl;
    logic [c_NIN-1:0] w_rise;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PLAYERS; gi++) begin : g_raw
            assign w_raw[2*gi]   = trigger[gi];
            assign w_raw[2*gi+1] = sens[gi];
        end

        for (gi = 0; gi < c_NIN; gi++) begin : g_in
            logic               r_s1;
            logic               r_s2;
            logic               r_lvl;
            logic [c_DEB_W-1:0] r_cnt;

            always_ff @(posedge CLK) begin
                if (!CLR) begin
                    r_s1  <= 1'b0;
                    r_s2  <= 1'b0;
                    r_lvl <= 1'b0;
                    r_cnt <= '0;
                end else begin
                    r_s1 <= w_raw[gi];
                    r_s2 <= r_s1;
                    if (r_s2 != r_lvl) begin
                        if (r_cnt == c_DEB_LAST) begin
                            r_lvl <= r_s2;
                            r_cnt <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end else begin
                        r_cnt <= '0;
                    end
                end
            end

            assign w_lvl[gi]  = r_lvl;
            // Rise is flagged on the same edge the new level is accepted
            assign w_rise[gi] = r_s2 && !r_lvl && (r_cnt == c_DEB_LAST);
        end
    endgenerate

    logic [NUM_PLAYERS-1:0][9:0] w_preg;

    generate
        for (gi = 0; gi < NUM_PLAYERS; gi++) begin : g_player
            logic [c_PULSE_W-1:0] r_shot_cnt;
            logic [c_PULSE_W-1:0] r_hit_cnt;
            logic [1:0]           r_evt;
            logic [7:0]           r_hcnt;
            logic                 w_tedge;
            logic                 w_sedge;
            logic                 w_pwr;
            logic [1:0]           w_w1c;

            assign w_tedge = w_rise[2*gi];
            assign w_sedge = w_rise[2*gi+1];
            assign w_pwr   = bus_wr && w_dec && (w_lo == 8'(8'h10 + gi));
            assign w_w1c   = w_pwr ? bus_din[1:0] : 2'b00;

            always_ff @(posedge CLK) begin
                if (!CLR) begin
                    r_shot_cnt <= '0;
                    r_hit_cnt  <= '0;
                    r_evt      <= 2'b00;
                    r_hcnt     <= 8'h00;
                end else begin
                    if (w_tedge)
                        r_shot_cnt <= c_PULSE_LD;
                    else if (r_shot_cnt != '0)
                        r_shot_cnt <= r_shot_cnt - c_PULSE_ONE;

                    if (w_sedge)
                        r_hit_cnt <= c_PULSE_LD;
                    else if (r_hit_cnt != '0)
                        r_hit_cnt <= r_hit_cnt - c_PULSE_ONE;

                    // New events take priority over a coincident clear
                    r_evt <= (r_evt & ~w_w1c) | {w_sedge, w_tedge};

                    if (w_pwr && bus_din[DATA_W-1])
                        r_hcnt <= {7'd0, w_sedge};
                    else if (w_sedge && r_hcnt != 8'hFF)
                        r_hcnt <= r_hcnt + 8'd1;
                end
            end

            assign shot[gi]   = (r_shot_cnt != '0);
            assign hit[gi]    = (r_hit_cnt != '0);
            assign w_preg[gi] = {r_hcnt, r_evt};
        end
    endgenerate

    logic [NUM_SOUNDS-1:0][DATA_W-1:0] w_stmr;

    generate
        for (gi = 0; gi < NUM_SOUNDS; gi++) begin : g_sound
            logic [DATA_W-1:0] r_tmr;
            logic              w_swr;

            assign w_swr = bus_wr && w_dec && (w_lo == 8'(8'h20 + gi));

            always_ff @(posedge CLK) begin
                if (!CLR)
                    r_tmr <= '0;
                else if (w_swr)
                    r_tmr <= bus_din;
                else if (r_tmr != '0)
                    r_tmr <= r_tmr - c_TMR_ONE;
            end

            assign sound[gi]  = (r_tmr != '0);
            assign w_stmr[gi] = r_tmr;
        end
    endgenerate

    logic [9:0] r_lfsr;

    always_ff @(posedge CLK) begin
        if (!CLR)
            r_lfsr <= 10'h001;
        else
            r_lfsr <= {r_lfsr[8:0], r_lfsr[9] ^ r_lfsr[6]};
    end

    assign rand_out = r_lfsr;

    logic [DATA_W-1:0] w_rdata;

    always_comb begin
        w_rdata = '0;
        if (w_dec) begin
            for (int p = 0; p < NUM_PLAYERS; p++)
                if (w_lo == 8'(8'h10 + p))
                    w_rdata = DATA_W'(w_preg[p]);
            for (int s = 0; s < NUM_SOUNDS; s++)
                if (w_lo == 8'(8'h20 + s))
                    w_rdata = w_stmr[s];
            if (w_lo == 8'h30)
                w_rdata = DATA_W'(r_lfsr);
            if (w_lo == 8'h31)
                w_rdata = DATA_W'(w_lvl);
        end
    end

    always_ff @(posedge CLK) begin
        if (!CLR) begin
            bus_dout <= '0;
            bus_sel  <= 1'b0;
        end else begin
            bus_dout <= w_rdata;
            bus_sel  <= w_dec;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_io_map_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_io_map_multi
// Description : Scoreboard bench for io_map_multi (default parameters).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_io_map_multi;

    localparam int c_NP = 2;
    localparam int c_NS = 8;
    localparam int c_DW = 18;
    localparam int c_AW = 16;

    logic            CLK = 1'b0;
    logic            CLR;
    logic [c_NP-1:0] trigger;
    logic [c_NP-1:0] sens;
    logic [c_NP-1:0] shot;
    logic [c_NP-1:0] hit;
    logic [c_NS-1:0] sound;
    logic            bus_wr;
    logic [c_AW-1:0] bus_addr;
    logic [c_DW-1:0] bus_din;
    logic [c_DW-1:0] bus_dout;
    logic            bus_sel;
    logic [9:0]      rand_out;

    int n_vec = 0;
    int n_err = 0;

    logic [c_DW:0] exp_q[$];
    string         tag_q[$];

    io_map_multi #(
        .NUM_PLAYERS(c_NP), .NUM_SOUNDS(c_NS), .DATA_W(c_DW), .ADDR_W(c_AW),
        .IO_BASE(16'h2000), .DEB_CYC(4), .PULSE_LEN(8)
    ) dut (
        .CLK(CLK), .CLR(CLR), .trigger(trigger), .sens(sens), .shot(shot),
        .hit(hit), .sound(sound), .bus_wr(bus_wr), .bus_addr(bus_addr),
        .bus_din(bus_din), .bus_dout(bus_dout), .bus_sel(bus_sel),
        .rand_out(rand_out)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic bus_write(input logic [c_AW-1:0] a, input logic [c_DW-1:0] d);
        bus_wr   = 1'b1;
        bus_addr = a;
        bus_din  = d;
        tick();
        bus_wr   = 1'b0;
        bus_addr = '0;
        bus_din  = '0;
    endtask

    task automatic bus_read(input string tag, input logic [c_AW-1:0] a,
                            input logic esel, input logic [c_DW-1:0] edout);
        logic [c_DW:0] e;
        bus_wr   = 1'b0;
        bus_addr = a;
        exp_q.push_back({esel, edout});
        tag_q.push_back(tag);
        tick();
        e = exp_q.pop_front();
        chk(tag_q.pop_front(), 32'({bus_sel, bus_dout}), 32'(e));
        bus_addr = '0;
    endtask

    initial begin
        int  first, n, g, exp_cnt, zeros, reps;
        logic [9:0] v;
        bit  seen [0:1023];

        CLR = 1'b0; trigger = '0; sens = '0;
        bus_wr = 1'b0; bus_addr = '0; bus_din = '0;

        // Reset with inputs and bus activity toggling
        for (int i = 0; i < 2; i++) begin
            trigger  = ~trigger;
            sens     = ~sens;
            bus_wr   = 1'b1;
            bus_addr = 16'h2023;
            bus_din  = 18'h5;
            tick();
        end
        chk("rst_shot",  32'(shot), 0);
        chk("rst_hit",   32'(hit), 0);
        chk("rst_sound", 32'(sound), 0);
        chk("rst_dout",  32'(bus_dout), 0);
        chk("rst_sel",   32'(bus_sel), 0);
        chk("rst_rand",  32'(rand_out), 1);
        trigger = '0; sens = '0; bus_wr = 1'b0; bus_addr = '0; bus_din = '0;
        CLR = 1'b1;

        // LFSR period from the reset seed
        for (int i = 0; i < 1024; i++) seen[i] = 1'b0;
        seen[1] = 1'b1;
        zeros = 0; reps = 0;
        for (int i = 1; i <= 1023; i++) begin
            tick();
            v = rand_out;
            if (i == 1) chk("rand_moves", 32'(v != 10'h001), 1);
            if (i < 1023) begin
                if (v == 10'h000) zeros++;
                if (seen[v]) reps++;
                seen[v] = 1'b1;
            end
        end
        chk("lfsr_zero",   32'(zeros), 0);
        chk("lfsr_repeat", 32'(reps), 0);
        chk("lfsr_period", 32'(rand_out), 1);
        chk("post_rst_sound", 32'(sound), 0);

        // Short glitch must be filtered
        trigger[0] = 1'b1;
        tick(); tick();
        trigger[0] = 1'b0;
        g = 0;
        for (int j = 0; j < 12; j++) begin
            tick();
            if (shot[0]) g++;
        end
        chk("glitch_shot", 32'(g), 0);
        bus_read("glitch_evt", 16'h2010, 1'b1, 18'h0);

        // Stable press: pulse starts 2+DEB_CYC edges later, lasts PULSE_LEN
        trigger[0] = 1'b1;
        first = -1; n = 0;
        for (int j = 1; j <= 20; j++) begin
            if (j == 11) trigger[0] = 1'b0;
            tick();
            if (shot[0]) begin
                n++;
                if (first < 0) first = j;
            end
        end
        chk("shot_start", 32'(first), 6);
        chk("shot_len",   32'(n), 8);
        bus_read("evt_trig", 16'h2010, 1'b1, 18'h1);
        bus_write(16'h2010, 18'h1);
        bus_read("evt_w1c", 16'h2010, 1'b1, 18'h0);

        // 300 sensor hits saturate the count
        exp_cnt = 0;
        for (int k = 0; k < 300; k++) begin
            sens[1] = 1'b1;
            for (int j = 1; j <= 7; j++) begin
                tick();
                if (k == 0 && j == 5) chk("hit_pre", 32'(hit[1]), 0);
                if (k == 0 && j == 6) chk("hit_on",  32'(hit[1]), 1);
            end
            sens[1] = 1'b0;
            repeat (7) tick();
            if (exp_cnt < 255) exp_cnt++;
        end
        bus_read("hit_sat", 16'h2011, 1'b1, 18'(exp_cnt * 4 + 2));
        bus_write(16'h2011, 18'h20000);
        bus_read("hit_clr", 16'h2011, 1'b1, 18'h2);

        // Sensor edge coincides with count-clear and W1C of the same event
        sens[1] = 1'b1;
        repeat (5) tick();
        bus_write(16'h2011, 18'h20002);
        bus_read("levels", 16'h2031, 1'b1, 18'h8);
        bus_read("hit_race", 16'h2011, 1'b1, 18'h6);
        sens[1] = 1'b0;
        repeat (8) tick();

        // Sound one-shot
        n = 0;
        bus_write(16'h2023, 18'd5);
        if (sound[3]) n++;
        tick();
        if (sound[3]) n++;
        for (int t = 4; t >= 0; t--) begin
            bus_read("snd_count", 16'h2023, 1'b1, 18'(t));
            if (sound[3]) n++;
        end
        tick();
        if (sound[3]) n++;
        chk("snd_len", 32'(n), 5);

        bus_write(16'h2023, 18'd10);
        tick();
        bus_write(16'h2023, 18'd3);
        n = sound[3] ? 1 : 0;
        for (int t = 3; t >= 0; t--) begin
            bus_read("snd_restart_rd", 16'h2023, 1'b1, 18'(t));
            if (sound[3]) n++;
        end
        chk("snd_restart_len", 32'(n), 3);

        bus_write(16'h2023, 18'd10);
        chk("snd_run",  32'(sound), 32'h08);
        bus_write(16'h2023, 18'd0);
        chk("snd_stop", 32'(sound), 0);

        // Decode boundaries and unimplemented offsets
        bus_read("dec_below", 16'h1FFF, 1'b0, 18'h0);
        bus_write(16'h2100, 18'h3FFFF);
        bus_read("dec_above", 16'h2100, 1'b0, 18'h0);
        bus_read("dec_gap_p", 16'h2012, 1'b1, 18'h0);
        bus_read("dec_gap_s", 16'h2028, 1'b1, 18'h0);
        bus_read("rand_read", 16'h2030, 1'b1, 18'(rand_out));
        chk("stray_sound", 32'(sound), 0);

        // Reset in the middle of a sound
        bus_write(16'h2025, 18'd100);
        chk("snd5_on", 32'(sound), 32'h20);
        CLR = 1'b0;
        tick();
        chk("rst_mid_sound", 32'(sound), 0);
        chk("rst_mid_rand",  32'(rand_out), 1);
        CLR = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
